// File: rtl/fft_stage_sequencer.sv
// FFT stage sequencer: walks every butterfly of an N-point transform stage by
// stage, issues RAM reads, delays them into butterfly starts, and retires
// results through an in-order write-back address FIFO.
module fft_stage_sequencer #(
  parameter int LOG_N      = 12,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_ct_in,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-2:0] tw_addr,
  output logic             bf_start,
  output logic             bf_use_ct,
  input  logic             bf_done,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b,
  output logic             err
);

  localparam int HALF = 1 << (LOG_N - 1);
  localparam int SW   = (LOG_N > 1) ? $clog2(LOG_N) : 1;
  localparam int PW   = SW + 1;
  localparam int FAW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [LOG_N-2:0] J_LAST   = (LOG_N-1)'(HALF - 1);
  localparam logic [SW-1:0]    S_LAST   = SW'(LOG_N - 1);
  localparam logic [FAW-1:0]   PTR_LAST = FAW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  logic [SW-1:0]        r_stage;
  logic [LOG_N-2:0]     r_j;
  logic                 r_use_ct;
  logic                 r_err;
  logic                 r_flush;
  logic [LOG_N:0]       r_outstanding;
  logic [RD_LATENCY-1:0] r_rd_dly;
  logic [2*LOG_N-1:0]   r_fifo [FIFO_DEPTH];
  logic [FAW-1:0]       r_wptr;
  logic [FAW-1:0]       r_rptr;
  logic [FCW-1:0]       r_count;

  logic                 w_issue;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic                 w_pop;
  logic                 w_push_ok;
  logic [PW-1:0]        w_p;
  logic [LOG_N-1:0]     w_j_ext;
  logic [LOG_N-1:0]     w_mask;
  logic [LOG_N-1:0]     w_off;
  logic [LOG_N-1:0]     w_a;
  logic [LOG_N-1:0]     w_b;
  logic [LOG_N-1:0]     w_tw_full;
  logic [2*LOG_N-1:0]   w_head;

  assign w_issue      = (r_state == S_ISSUE);
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == FCW'(FIFO_DEPTH));
  assign w_pop        = bf_done && !w_fifo_empty;
  assign w_push_ok    = w_issue && (!w_fifo_full || w_pop);
  assign w_head       = r_fifo[r_rptr];

  // Butterfly addressing: a is j with a zero bit inserted at position p, b sets that bit.
  always_comb begin
    w_p       = r_use_ct ? PW'(r_stage) : (PW'(LOG_N - 1) - PW'(r_stage));
    w_j_ext   = {1'b0, r_j};
    w_mask    = (LOG_N'(1) << w_p) - LOG_N'(1);
    w_off     = w_j_ext & w_mask;
    w_a       = ((w_j_ext >> w_p) << (w_p + PW'(1))) | w_off;
    w_b       = w_a | (LOG_N'(1) << w_p);
    w_tw_full = w_off << (PW'(LOG_N - 1) - w_p);
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign rd_en     = w_issue;
  assign rd_addr_a = w_issue ? w_a : '0;
  assign rd_addr_b = w_issue ? w_b : '0;
  assign tw_addr   = w_issue ? w_tw_full[LOG_N-2:0] : '0;
  assign bf_start  = r_rd_dly[RD_LATENCY-1];
  assign bf_use_ct = r_use_ct;
  assign wr_en     = w_pop;
  assign wr_addr_a = w_pop ? w_head[2*LOG_N-1:LOG_N] : '0;
  assign wr_addr_b = w_pop ? w_head[LOG_N-1:0] : '0;
  assign err       = r_err;

  // Main sequencer: issue a stage, drain it completely, advance to the next stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_stage  <= '0;
      r_j      <= '0;
      r_use_ct <= 1'b0;
      // Remember that butterflies may still be in flight so their late dones are ignored.
      r_flush  <= r_flush || (r_state != S_IDLE) || (r_outstanding != '0);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_use_ct <= use_ct_in;
            r_stage  <= '0;
            r_j      <= '0;
            r_flush  <= 1'b0;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_j == J_LAST) begin
            r_j     <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_j <= r_j + (LOG_N-1)'(1);
          end
        end
        S_DRAIN: begin
          if (r_outstanding == '0) begin
            if (r_stage == S_LAST) begin
              r_state <= S_DONE;
            end else begin
              r_stage <= r_stage + SW'(1);
              r_state <= S_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky error: completion with nothing queued, or a push into a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_err <= 1'b0;
    end else if ((bf_done && w_fifo_empty && !r_flush) || (w_issue && w_fifo_full && !w_pop)) begin
      r_err <= 1'b1;
    end
  end

  // Read strobe delay line that produces the butterfly start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_dly <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        r_rd_dly[i] <= r_rd_dly[i-1];
      end
      r_rd_dly[0] <= w_issue;
    end
  end

  // Butterflies in flight between issue and write-back; gates the stage change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_push_ok, w_pop})
        2'b10:   r_outstanding <= r_outstanding + (LOG_N+1)'(1);
        2'b01:   r_outstanding <= r_outstanding - (LOG_N+1)'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Write-back address FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + FAW'(1);
      if (w_pop)     r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + FAW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + FCW'(1);
        2'b01:   r_count <= r_count - FCW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage holds the read address pair of each issued butterfly.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wptr] <= {w_a, w_b};
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Testbench for fft_stage_sequencer (LOG_N=3): scoreboard of expected read
// tuples and write-back addresses against a 10-cycle butterfly model.
module tb_fft_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, use_ct_in;
  logic       busy, done, rd_en, bf_start, bf_use_ct, bf_done, wr_en, err;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_addr;
  logic       spur;
  logic [9:0] pipe = '0;

  int tests = 0;
  int fails = 0;

  fft_stage_sequencer #(.LOG_N(3), .RD_LATENCY(1), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .use_ct_in(use_ct_in),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .bf_start(bf_start), .bf_use_ct(bf_use_ct), .bf_done(bf_done),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .err(err)
  );

  always #5 clk = ~clk;

  // Butterfly model: done 10 cycles after start; never reset, so in-flight work survives rst.
  always @(posedge clk) pipe <= {pipe[8:0], bf_start};
  assign bf_done = pipe[9] | spur;

  task automatic run_transform(input logic mode, input logic poke);
    int exp_rd[$];
    int exp_wr[$];
    int rd_cyc[$];
    int cyc, wr_cnt, rd_idx, e, rc, h, p, a, b, tw;
    logic prev_rd;
    bit finished;
    for (int s = 0; s < 3; s++) begin
      h = mode ? (1 << s) : (4 >> s);
      p = mode ? s : 2 - s;
      for (int j = 0; j < 4; j++) begin
        a  = (j / h) * 2 * h + (j % h);
        b  = a + h;
        tw = (j % h) * (1 << (2 - p));
        exp_rd.push_back((a << 5) | (b << 2) | tw);
        exp_wr.push_back((a << 3) | b);
      end
    end
    cyc = 0; wr_cnt = 0; rd_idx = 0; prev_rd = 1'b0; finished = 0;
    @(negedge clk);
    start = 1'b1; use_ct_in = mode;
    while (!finished && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; use_ct_in = ~mode;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busy cyc=%0d got=%b exp=1", cyc, busy); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_run cyc=%0d got=%b exp=0", cyc, err); end
      tests++; if (bf_start !== prev_rd) begin fails++; $display("FAIL bf_start cyc=%0d got=%b exp=%b", cyc, bf_start, prev_rd); end
      tests++; if (bf_use_ct !== mode) begin fails++; $display("FAIL bf_use_ct cyc=%0d got=%b exp=%b", cyc, bf_use_ct, mode); end
      if (rd_en === 1'b1) begin
        $display("[TB] rd idx=%0d a=%0d b=%0d tw=%0d", rd_idx, rd_addr_a, rd_addr_b, tw_addr);
        tests++;
        if (exp_rd.size() == 0) begin
          fails++; $display("FAIL rd_extra cyc=%0d got=rd_en exp=none", cyc);
        end else begin
          e = exp_rd.pop_front();
          if ({rd_addr_a, rd_addr_b, tw_addr} !== e[7:0]) begin
            fails++;
            $display("FAIL rd_tuple idx=%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", rd_idx,
                     rd_addr_a, rd_addr_b, tw_addr, e[7:5], e[4:2], e[1:0]);
          end
        end
        tests++;
        if (wr_cnt < (rd_idx / 4) * 4) begin
          fails++; $display("FAIL raw_order idx=%0d got_wr=%0d exp_min=%0d", rd_idx, wr_cnt, (rd_idx / 4) * 4);
        end
        rd_cyc.push_back(cyc);
        rd_idx++;
      end
      if (wr_en === 1'b1) begin
        $display("[TB] wr n=%0d a=%0d b=%0d", wr_cnt, wr_addr_a, wr_addr_b);
        tests++;
        if (exp_wr.size() == 0 || rd_cyc.size() == 0) begin
          fails++; $display("FAIL wr_extra cyc=%0d got=wr_en exp=none", cyc);
        end else begin
          e  = exp_wr.pop_front();
          rc = rd_cyc.pop_front();
          if ({wr_addr_a, wr_addr_b} !== e[5:0]) begin
            fails++;
            $display("FAIL wr_addr n=%0d got=(%0d,%0d) exp=(%0d,%0d)", wr_cnt, wr_addr_a, wr_addr_b, e[5:3], e[2:0]);
          end
          tests++;
          if (cyc - rc != 11) begin
            fails++; $display("FAIL wr_latency n=%0d got=%0d exp=11", wr_cnt, cyc - rc);
          end
        end
        wr_cnt++;
      end
      if (done === 1'b1) begin
        finished = 1;
        $display("[TB] done after %0d cycles, %0d writes", cyc, wr_cnt);
        tests++; if (wr_cnt != 12) begin fails++; $display("FAIL wr_count got=%0d exp=12", wr_cnt); end
        tests++; if (rd_idx != 12) begin fails++; $display("FAIL rd_count got=%0d exp=12", rd_idx); end
      end
      prev_rd = rd_en;
      if (poke && (cyc == 5 || cyc == 20)) begin
        start = 1'b1;
      end
    end
    start = 1'b0;
    if (!finished) begin
      tests++; fails++; $display("FAIL done_timeout got=no_done exp=done within 300 cycles");
    end
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_after got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if ({busy, done, rd_en, bf_start, wr_en, err} !== 6'b0) begin
      fails++; $display("FAIL reset_flags got=%b exp=000000", {busy, done, rd_en, bf_start, wr_en, err});
    end
    tests++; if ({rd_addr_a, rd_addr_b, tw_addr} !== 8'b0) begin
      fails++; $display("FAIL reset_rd_addr got=%h exp=00", {rd_addr_a, rd_addr_b, tw_addr});
    end
    tests++; if ({wr_addr_a, wr_addr_b} !== 6'b0) begin
      fails++; $display("FAIL reset_wr_addr got=%h exp=00", {wr_addr_a, wr_addr_b});
    end
    rst = 1'b0;
    $display("[TB] reset released");
  endtask

  task automatic test_ct_mode();
    $display("[TB] CT transform");
    run_transform(1'b1, 1'b0);
  endtask

  task automatic test_gs_mode();
    $display("[TB] GS transform");
    run_transform(1'b0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    $display("[TB] CT transform with start pokes while busy");
    run_transform(1'b1, 1'b1);
  endtask

  task automatic test_spurious_done();
    @(negedge clk);
    spur = 1'b1;
    #1;
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL spur_wr_en got=%b exp=0", wr_en); end
    @(negedge clk);
    spur = 1'b0;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL spur_err got=%b exp=1", err); end
    @(negedge clk);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got=%b exp=1", err); end
    $display("[TB] spurious bf_done flagged, restarting");
    run_transform(1'b0, 1'b0);
  endtask

  task automatic test_rst_abort();
    int n = 0;
    @(negedge clk);
    start = 1'b1; use_ct_in = 1'b1;
    for (int c = 0; c < 100 && n < 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en === 1'b1) n++;
    end
    if (n < 5) begin
      tests++; fails++; $display("FAIL abort_timeout got=%0d exp=5 reads", n);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if ({busy, done, rd_en, bf_start, wr_en, err} !== 6'b0) begin
      fails++; $display("FAIL abort_flags got=%b exp=000000", {busy, done, rd_en, bf_start, wr_en, err});
    end
    tests++; if ({rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== 14'b0) begin
      fails++; $display("FAIL abort_addr got=%h exp=0", {rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b});
    end
    n = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bf_done === 1'b1) n++;
      tests++; if ({rd_en, wr_en, err, busy} !== 4'b0) begin
        fails++; $display("FAIL abort_quiet c=%0d got=%b exp=0000", c, {rd_en, wr_en, err, busy});
      end
    end
    $display("[TB] abort: %0d late bf_done ignored", n);
    run_transform(1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; use_ct_in = 1'b0; spur = 1'b0;
    test_reset();
    test_ct_mode();
    test_gs_mode();
    test_start_while_busy();
    test_spurious_done();
    test_rst_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
